button_input: RTL and testbench

Input-side counterpart to the board's LED PWM chaser. Conditions one raw mechanical push-button pin into clean single-cycle event strobes: press, release (short/long qualified), long-press and auto-repeat. Sits between the board pin and any control logic (speed/direction select, mode stepping) that consumes button events.

---
 rtl/button_input.sv | 151 +++++++++++++++
 tb/tb_button_input.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/button_input.sv
// Push-button conditioner: synchronizer, debounce and press/release/long/repeat strobes.
// All event outputs are registered; nothing downstream of the synchronizer sees the raw pin.
module button_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned LONG_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_in_i,
  output logic btn_level_o,
  output logic press_o,
  output logic release_o,
  output logic release_short_o,
  output logic long_press_o,
  output logic repeat_o
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int unsigned RPT_W  = (REPEAT_CYCLES == 0) ? 1 : $clog2(REPEAT_CYCLES + 1);
  localparam bit          RPT_EN = (REPEAT_CYCLES != 0);

  // Terminal values are one below the parameter: the cycle that reaches the count fires.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(RPT_EN ? REPEAT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_e;

  state_e              state_q, state_d;
  logic                pin_pressed;
  logic                sync1_q, sync2_q;
  logic                stable_q, stable_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [RPT_W-1:0]    rpt_q, rpt_d;
  logic                press_d, release_d, short_d, long_d, repeat_d;

  assign pin_pressed = ACTIVE_LOW ? ~btn_in_i : btn_in_i;

  // State, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q         <= 1'b0;
      sync2_q         <= 1'b0;
      stable_q        <= 1'b0;
      db_cnt_q        <= '0;
      hold_q          <= '0;
      rpt_q           <= '0;
      state_q         <= IDLE;
      btn_level_o     <= 1'b0;
      press_o         <= 1'b0;
      release_o       <= 1'b0;
      release_short_o <= 1'b0;
      long_press_o    <= 1'b0;
      repeat_o        <= 1'b0;
    end else begin
      sync1_q         <= pin_pressed;
      sync2_q         <= sync1_q;
      stable_q        <= stable_d;
      db_cnt_q        <= db_cnt_d;
      hold_q          <= hold_d;
      rpt_q           <= rpt_d;
      state_q         <= state_d;
      btn_level_o     <= stable_q;
      press_o         <= press_d;
      release_o       <= release_d;
      release_short_o <= short_d;
      long_press_o    <= long_d;
      repeat_o        <= repeat_d;
    end
  end

  // Debounce: count consecutive cycles of disagreement with the stable level.
  always_comb begin
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d = '0;
      stable_d = ~stable_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Next-state and hold/repeat counters.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rpt_d   = rpt_q;
    case (state_q)
      IDLE: begin
        if (stable_q) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        if (!stable_q) begin
          state_d = IDLE;
        end else if (hold_q == HOLD_LAST) begin
          state_d = HELD;
          rpt_d   = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      HELD: begin
        if (!stable_q) begin
          state_d = IDLE;
        end else if (RPT_EN) begin
          rpt_d = (rpt_q == RPT_LAST) ? '0 : rpt_q + RPT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe decode; a release suppresses any coincident long/repeat.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: press_d = stable_q;
      PRESSED: begin
        if (!stable_q) begin
          release_d = 1'b1;
          short_d   = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          long_d = 1'b1;
        end
      end
      HELD: begin
        if (!stable_q) begin
          release_d = 1'b1;
        end else if (RPT_EN && (rpt_q == RPT_LAST)) begin
          repeat_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_button_input.sv
// Scoreboard bench for button_input: expected strobe events (cycle, kind, short flag)
// are queued when the pin is driven and popped as the DUT emits strobes.
module tb_button_input;

  localparam int DB_C   = 4;
  localparam int LONG_C = 20;
  localparam int RPT_C  = 8;
  localparam int K_PRESS = 1, K_REL = 2, K_LONG = 3, K_RPT = 4;

  typedef struct {
    int cyc;
    int kind;
    int shrt;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic pin_a, pin_b;
  logic lvl_a, pr_a, rl_a, rs_a, lp_a, rp_a;
  logic lvl_b, pr_b, rl_b, rs_b, lp_b, rp_b;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  ev_t  exp_a[$];
  ev_t  exp_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_input #(.DEBOUNCE_CYCLES(DB_C), .LONG_CYCLES(LONG_C), .REPEAT_CYCLES(RPT_C),
                 .ACTIVE_LOW(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .btn_in_i(pin_a), .btn_level_o(lvl_a), .press_o(pr_a),
    .release_o(rl_a), .release_short_o(rs_a), .long_press_o(lp_a), .repeat_o(rp_a));

  button_input #(.DEBOUNCE_CYCLES(DB_C), .LONG_CYCLES(LONG_C), .REPEAT_CYCLES(0),
                 .ACTIVE_LOW(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .btn_in_i(pin_b), .btn_level_o(lvl_b), .press_o(pr_b),
    .release_o(rl_b), .release_short_o(rs_b), .long_press_o(lp_b), .repeat_o(rp_b));

  task automatic check_eq(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
  endtask

  task automatic push_ev(input int which, input int c, input int kind, input int shrt);
    ev_t e;
    e.cyc = c; e.kind = kind; e.shrt = shrt;
    if (which == 0) exp_a.push_back(e);
    else exp_b.push_back(e);
  endtask

  // Model of one hold: press already queued at p, stable release observed at rel.
  task automatic push_model(input int which, input int p, input int rel, input bit rpt_en);
    if (p + LONG_C < rel) begin
      push_ev(which, p + LONG_C, K_LONG, 0);
      if (rpt_en)
        for (int t = p + LONG_C + RPT_C; t < rel; t += RPT_C) push_ev(which, t, K_RPT, 0);
      push_ev(which, rel, K_REL, 0);
    end else begin
      push_ev(which, rel, K_REL, 1);
    end
  endtask

  task automatic mon_one(input int which, input int kind, input int shrt);
    ev_t e;
    int  empty;
    empty = (which == 0) ? exp_a.size() : exp_b.size();
    if (empty == 0) begin
      check_eq(which == 0 ? "spurious_a" : "spurious_b", kind, 0);
    end else begin
      if (which == 0) e = exp_a.pop_front();
      else e = exp_b.pop_front();
      check_eq(which == 0 ? "kind_a" : "kind_b", kind, e.kind);
      check_eq(which == 0 ? "cyc_a" : "cyc_b", cyc, e.cyc);
      if (kind == K_REL) check_eq(which == 0 ? "short_a" : "short_b", shrt, e.shrt);
    end
  endtask

  always @(negedge clk) begin
    if (pr_a) mon_one(0, K_PRESS, 0);
    if (rl_a) mon_one(0, K_REL, int'(rs_a));
    if (lp_a) mon_one(0, K_LONG, 0);
    if (rp_a) mon_one(0, K_RPT, 0);
    if (!rl_a && rs_a) check_eq("short_no_rel_a", 1, 0);
    if (pr_b) mon_one(1, K_PRESS, 0);
    if (rl_b) mon_one(1, K_REL, int'(rs_b));
    if (lp_b) mon_one(1, K_LONG, 0);
    if (rp_b) mon_one(1, K_RPT, 0);
    if (!rl_b && rs_b) check_eq("short_no_rel_b", 1, 0);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle_a(input string tag);
    check_eq({tag, "_lvl"}, int'(lvl_a), 0);
    check_eq({tag, "_press"}, int'(pr_a), 0);
    check_eq({tag, "_rel"}, int'(rl_a), 0);
    check_eq({tag, "_short"}, int'(rs_a), 0);
    check_eq({tag, "_long"}, int'(lp_a), 0);
    check_eq({tag, "_rpt"}, int'(rp_a), 0);
  endtask

  initial begin
    int p, p2;
    rst = 1'b1;
    pin_a = 1'b1;
    pin_b = 1'b0;
    wait_cyc(3);
    check_idle_a("reset");
    check_eq("reset_lvl_b", int'(lvl_b), 0);
    rst = 1'b0;
    wait_cyc(5);

    // 1 + 3: bounce into a press, short hold, clean release.
    for (int i = 0; i < 6; i++) begin
      pin_a = (i % 2 == 1);
      wait_cyc(2);
    end
    pin_a = 1'b0;
    p = cyc + DB_C + 3;
    push_ev(0, p, K_PRESS, 0);
    push_model(0, p, p + 10 + DB_C + 3, 1'b1);
    wait_cyc(DB_C + 2);
    check_eq("bounce_lvl_before", int'(lvl_a), 0);
    wait_cyc(1);
    check_eq("bounce_lvl_after", int'(lvl_a), 1);
    wait_cyc(10);
    pin_a = 1'b1;
    wait_cyc(DB_C + 2);
    check_eq("short_lvl_before", int'(lvl_a), 1);
    wait_cyc(1);
    check_eq("short_lvl_after", int'(lvl_a), 0);
    wait_cyc(10);

    // 2: glitch shorter than the debounce window.
    pin_a = 1'b0;
    wait_cyc(DB_C - 1);
    pin_a = 1'b1;
    wait_cyc(12);
    check_eq("glitch_lvl", int'(lvl_a), 0);

    // 4: long press with repeats, released 50 cycles after press.
    pin_a = 1'b0;
    p = cyc + DB_C + 3;
    push_ev(0, p, K_PRESS, 0);
    push_model(0, p, p + 50 + DB_C + 3, 1'b1);
    wait_cyc(DB_C + 3 + 50);
    check_eq("long_lvl_held", int'(lvl_a), 1);
    pin_a = 1'b1;
    wait_cyc(12);

    // 5: reset mid-hold, pin still pressed -> fresh press after reset.
    pin_a = 1'b0;
    p = cyc + DB_C + 3;
    push_ev(0, p, K_PRESS, 0);
    push_ev(0, p + LONG_C, K_LONG, 0);
    wait_cyc(DB_C + 3 + 25);
    rst = 1'b1;
    wait_cyc(1);
    check_idle_a("midrst");
    rst = 1'b0;
    p2 = cyc + DB_C + 3;
    check_eq("midrst_press_gap", p2 - p, 33);
    push_ev(0, p2, K_PRESS, 0);
    push_model(0, p2, p2 + 30 + DB_C + 3, 1'b1);
    wait_cyc(DB_C + 3 + 30);
    pin_a = 1'b1;
    wait_cyc(12);

    // 6: active-high pin, repeat disabled.
    pin_b = 1'b1;
    p = cyc + DB_C + 3;
    push_ev(1, p, K_PRESS, 0);
    push_model(1, p, p + 60 + DB_C + 3, 1'b0);
    wait_cyc(DB_C + 3 + 60);
    check_eq("b_lvl_held", int'(lvl_b), 1);
    pin_b = 1'b0;
    wait_cyc(12);
    check_eq("b_lvl_released", int'(lvl_b), 0);

    check_eq("pending_a", exp_a.size(), 0);
    check_eq("pending_b", exp_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
